// File: rtl/pattern_gen_pkg.sv
// Shared FSM state encoding and default widths for the increment-pattern generator.
package pattern_gen_pkg;

  localparam int unsigned DEF_CNT_WIDTH = 8;
  localparam int unsigned DEF_LEN_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter
  import pattern_gen_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_LEN_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pattern_generator.sv
// Valid/ready burst source emitting seed, seed+1, ... with early stop and continuous mode.
// Optional error injection is enabled by defining PATTERN_GEN_ERR_INJECT_EN.
module pattern_generator
  import pattern_gen_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int unsigned LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_WIDTH-1:0] seed,
  input  logic [LEN_WIDTH-1:0] burst_len,
  output logic [CNT_WIDTH-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] beat_count
`ifdef PATTERN_GEN_ERR_INJECT_EN
  ,
  input  logic                 inject_err,
  output logic [LEN_WIDTH-1:0] inject_count
`endif
);

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] data_out_d;
  logic                 stop_q, stop_d;
  logic                 data_valid_d, busy_d, done_d;

  logic load_c, accept_c, last_c, end_c, inj_now_c;

  assign load_c   = (state_q == IDLE) && start;
  assign accept_c = (state_q == RUN) && data_valid && data_ready;
  // Burst length 0 never matches, which gives continuous mode.
  assign last_c   = (len_q != '0) && (beat_count == (len_q - LEN_WIDTH'(1)));
  assign end_c    = accept_c && (last_c || stop_q || stop);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      stop_q     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      stop_q     <= stop_d;
      data_out   <= data_out_d;
      data_valid <= data_valid_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (end_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    len_d        = len_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out;
    stop_d       = (state_q == RUN) && !end_c && (stop_q || stop);
    data_valid_d = (state_d == RUN);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    if (load_c) begin
      len_d      = burst_len;
      cnt_d      = seed;
      data_out_d = seed;
    end else if (accept_c) begin
      cnt_d      = cnt_q + CNT_WIDTH'(1);
      data_out_d = cnt_d ^ CNT_WIDTH'(inj_now_c);
    end
  end

  sat_counter #(.WIDTH(LEN_WIDTH)) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (load_c),
    .inc   (accept_c),
    .count (beat_count)
  );

`ifdef PATTERN_GEN_ERR_INJECT_EN
  logic pend_q, corrupt_q;

  // A request arriving while a beat is offered corrupts the beat after it.
  assign inj_now_c = pend_q || inject_err;

  always_ff @(posedge clk) begin
    if (rst || load_c || (state_q != RUN)) begin
      pend_q    <= 1'b0;
      corrupt_q <= 1'b0;
    end else if (accept_c) begin
      pend_q    <= 1'b0;
      corrupt_q <= inj_now_c;
    end else begin
      pend_q    <= inj_now_c;
    end
  end

  sat_counter #(.WIDTH(LEN_WIDTH)) u_inject_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (load_c),
    .inc   (accept_c && corrupt_q),
    .count (inject_count)
  );
`else
  assign inj_now_c = 1'b0;
`endif

endmodule

// File: doc/pattern_generator.md
PATTERN_GENERATOR -- requirements
Module: pattern_generator

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 8, giving the data word width.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 16, giving the burst length and beat counter width.
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to begin a burst.
REQ-006 The block SHALL have port stop, input, 1, a request to end a burst early.
REQ-007 The block SHALL have port seed, input, CNT_WIDTH, the first data value, sampled on start.
REQ-008 The block SHALL have port burst_len, input, LEN_WIDTH, the beat count sampled on start, where 0 means continuous.
REQ-009 The block SHALL have port data_out, output, CNT_WIDTH, the increment-pattern word.
REQ-010 The block SHALL have port data_valid, output, 1, asserted when data_out is offered.
REQ-011 The block SHALL have port data_ready, input, 1, the sink acceptance; a beat transfers when data_valid and data_ready are both 1.
REQ-012 The block SHALL have port busy, output, 1, equal to 1 whenever the state is not IDLE.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse at burst end.
REQ-014 The block SHALL have port beat_count, output, LEN_WIDTH, the number of beats accepted in the current or last burst.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 In IDLE, start SHALL load seed into data_out, load burst_len, clear beat_count and enter RUN on the next cycle, so that data_valid=1 with data_out=seed one cycle after start.
REQ-017 In RUN, data_valid SHALL be 1; data_out SHALL hold stable while data_valid=1 and data_ready=0.
REQ-018 Each accepted beat SHALL advance data_out by +1 modulo 2^CNT_WIDTH (0xFF wraps to 0x00) and increment beat_count, which saturates at all-ones.
REQ-019 In non-continuous mode, acceptance of beat number burst_len SHALL move the FSM to DONE with data_valid=0 on the following cycle.
REQ-020 stop asserted in RUN SHALL be latched; the pending beat SHALL still complete, and the FSM SHALL enter DONE after that beat is accepted, with no new beat offered.
REQ-021 stop coinciding with acceptance of the last beat SHALL produce exactly one DONE and one done pulse.
REQ-022 DONE SHALL last one cycle, assert done=1, and return to IDLE; beat_count SHALL hold its value until the next start.
REQ-023 start SHALL be ignored in RUN and in DONE; stop SHALL be ignored in IDLE.
REQ-024 Continuous mode (burst_len=0) SHALL run until stop; beat_count saturates and does not wrap.

Reset
REQ-025 rst=1 on a clock edge SHALL force IDLE and clear data_out, data_valid, busy, done, beat_count, the latched stop and all injection state, including when reset occurs mid-burst; any offered beat is abandoned.

Configuration
REQ-026 With macro PATTERN_GEN_ERR_INJECT_EN defined, the block SHALL add input inject_err (1 bit) and output inject_count (LEN_WIDTH bits, saturating, cleared on start and on reset).
REQ-027 With PATTERN_GEN_ERR_INJECT_EN defined, an inject_err pulse in RUN SHALL cause the next beat offered after the current one to carry the expected value XOR 1; the sequence then resumes at expected+1, and inject_count increments when the corrupted beat is accepted.
REQ-028 Without PATTERN_GEN_ERR_INJECT_EN, inject_err and inject_count SHALL be absent and data_out SHALL always be the pure increment pattern.

Structure
REQ-029 Package pattern_gen_pkg SHALL hold the FSM state enum and the default width constants.
REQ-030 Sub-module sat_counter (parameterised width, clear, increment, saturate) SHALL implement beat_count and inject_count.

Verification
REQ-031 Apply seed=0x10, burst_len=4, with data_ready held at 1 -> data_out sequence 0x10,0x11,0x12,0x13, then one done pulse, and beat_count=4.
REQ-032 Apply seed=0xFE, burst_len=3 -> data_out sequence 0xFE,0xFF,0x00, with the wrap occurring and no extra beat.
REQ-033 Hold data_ready=0 for 5 cycles mid-burst -> data_out and data_valid hold stable, and beat_count stays unchanged.
REQ-034 Run with burst_len=0, then assert stop after 7 accepted beats while a beat is pending -> that beat is accepted, beat_count=8, and done pulses once.
REQ-035 Apply rst for one cycle during the third beat of a burst_len=10 burst -> data_valid=0, busy=0 and beat_count=0 on the next cycle, and no done pulse.
REQ-036 With PATTERN_GEN_ERR_INJECT_EN defined, seed=0x00 and inject_err during beat 0x02 -> data_out sequence ...,0x02,0x02 (0x03^1),0x04, and inject_count=1.
